// File: rtl/alu_exec_unit_if.sv
// Request/response bundle for alu_exec_unit.
// master: drives start, AluOp, Funct, A, B; observes Result, Hi, Zero, busy, done, err.
// slave : the execution unit side of the same signals.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       AluOp;
  logic [5:0]       Funct;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] Hi;
  logic             Zero;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, AluOp, Funct, A, B,
    input  Result, Hi, Zero, busy, done, err
  );

  modport slave (
    input  start, AluOp, Funct, A, B,
    output Result, Hi, Zero, busy, done, err
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle integer execution unit: single-cycle ALU ops, 1-bit-per-cycle
// variable shifts and an iterative unsigned shift-add multiplier.
// Ports: clk, reset (sync, active-high), bus (alu_exec_unit_if.slave) carrying
// start/AluOp/Funct/A/B in and Result/Hi/Zero/busy/done/err out (all registered).
module alu_exec_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter bit          MULT_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  alu_exec_unit_if.slave bus
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = SW + 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, ALU, SHIFT, MULT} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT,
    OP_SLLV, OP_SRLV, OP_MULT, OP_ILL
  } op_t;

  state_t           state;
  op_t              op_c;
  logic [WIDTH-1:0] alu_c;
  logic [SW-1:0]    shamt_c;
  logic [WIDTH-1:0] sh0_c;
  logic             shl;
  logic [WIDTH-1:0] sh_acc;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    prod_n_c;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  function automatic logic [WIDTH-1:0] sh1(input logic [WIDTH-1:0] v, input logic left);
    sh1 = left ? (v << 1) : (v >> 1);
  endfunction

  // Opcode decode from AluOp / Funct
  always_comb begin
    op_c = OP_ILL;
    case (bus.AluOp)
      2'b00: op_c = OP_ADD;
      2'b01: op_c = OP_SUB;
      2'b11: op_c = OP_SLT;
      default: begin
        case (bus.Funct)
          6'b100000: op_c = OP_ADD;
          6'b100010: op_c = OP_SUB;
          6'b100100: op_c = OP_AND;
          6'b100101: op_c = OP_OR;
          6'b100111: op_c = OP_NOR;
          6'b101010: op_c = OP_SLT;
          6'b000100: op_c = OP_SLLV;
          6'b000110: op_c = OP_SRLV;
          6'b011000: op_c = MULT_EN ? OP_MULT : OP_ILL;
          default:   op_c = OP_ILL;
        endcase
      end
    endcase
  end

  // Single-cycle result from the live operands, used at accept
  always_comb begin
    alu_c = '0;
    case (op_c)
      OP_ADD:  alu_c = bus.A + bus.B;
      OP_SUB:  alu_c = bus.A - bus.B;
      OP_AND:  alu_c = bus.A & bus.B;
      OP_OR:   alu_c = bus.A | bus.B;
      OP_NOR:  alu_c = ~(bus.A | bus.B);
      OP_SLT:  alu_c = WIDTH'($signed(bus.A) < $signed(bus.B));
      default: alu_c = '0;
    endcase
  end

  // First shift step happens at accept so a shift by n finishes in cycle n
  always_comb begin
    shamt_c = bus.B[SW-1:0];
    sh0_c   = (shamt_c == '0) ? bus.A : sh1(bus.A, op_c == OP_SLLV);
  end

  always_comb begin
    prod_n_c = prod + (mplier[0] ? mcand : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bus.Result <= '0;
      bus.Hi     <= '0;
      bus.Zero   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;
      shl        <= 1'b0;
      sh_acc     <= '0;
      prod       <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            case (op_c)
              OP_SLLV, OP_SRLV: begin
                state  <= SHIFT;
                shl    <= (op_c == OP_SLLV);
                sh_acc <= sh0_c;
                cnt    <= CW'(shamt_c) - CW'(1);
                if (shamt_c <= SW'(1)) begin
                  bus.done   <= 1'b1;
                  bus.Result <= sh0_c;
                  bus.Zero   <= (sh0_c == '0);
                  bus.err    <= 1'b0;
                end
              end
              OP_MULT: begin
                // Bit 0 of B is consumed at accept; bits 1..WIDTH-1 in MULT
                state  <= MULT;
                prod   <= bus.B[0] ? PW'(bus.A) : '0;
                mcand  <= PW'(bus.A) << 1;
                mplier <= bus.B >> 1;
                cnt    <= CW'(WIDTH - 1);
              end
              default: begin
                state      <= ALU;
                bus.done   <= 1'b1;
                bus.Result <= alu_c;
                bus.Zero   <= (alu_c == '0);
                bus.err    <= (op_c == OP_ILL);
              end
            endcase
          end
        end
        ALU: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        SHIFT: begin
          if (bus.done) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            sh_acc <= sh1(sh_acc, shl);
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              bus.done   <= 1'b1;
              bus.Result <= sh1(sh_acc, shl);
              bus.Zero   <= (sh1(sh_acc, shl) == '0);
              bus.err    <= 1'b0;
            end
          end
        end
        MULT: begin
          if (bus.done) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            prod   <= prod_n_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              bus.done   <= 1'b1;
              bus.Result <= prod_n_c[WIDTH-1:0];
              bus.Hi     <= prod_n_c[PW-1:WIDTH];
              bus.Zero   <= (prod_n_c[WIDTH-1:0] == '0);
              bus.err    <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH=32) with a MULT_EN=0 companion instance.
module tb_alu_exec_unit;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   seen;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(W)) bus ();
  alu_exec_unit_if #(.WIDTH(W)) bus_nm ();

  alu_exec_unit #(.WIDTH(W), .MULT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  alu_exec_unit #(.WIDTH(W), .MULT_EN(1'b0)) dut_nm (
    .clk(clk), .reset(reset), .bus(bus_nm)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.AluOp = op; bus.Funct = f; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = 1;
    while (bus.done !== 1'b1 && l < 200) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [5:0] f,
                     input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                     input logic [31:0] exp_res, input logic exp_zero, input logic exp_err);
    int l;
    issue(op, f, a, b);
    chk({tag, "_busy1"}, 64'(bus.busy), 64'd1);
    wait_done(l);
    chk({tag, "_lat"}, 64'(l), 64'(exp_lat));
    chk({tag, "_res"}, 64'(bus.Result), 64'(exp_res));
    chk({tag, "_zero"}, 64'(bus.Zero), 64'(exp_zero));
    chk({tag, "_err"}, 64'(bus.err), 64'(exp_err));
    @(negedge clk);
    chk({tag, "_done0"}, 64'(bus.done), 64'd0);
    chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.AluOp = 2'b00; bus.Funct = 6'd0; bus.A = '0; bus.B = '0;
    bus_nm.start = 1'b0; bus_nm.AluOp = 2'b00; bus_nm.Funct = 6'd0; bus_nm.A = '0; bus_nm.B = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", 64'(bus.Result), 64'd0);
    chk("rst_hi", 64'(bus.Hi), 64'd0);
    chk("rst_zero", 64'(bus.Zero), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    reset = 1'b0;

    // ALU ops, latency 1
    run("sub",     2'b10, 6'b100010, 32'd5,          32'd7,          1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run("slt_op",  2'b11, 6'b000000, 32'hFFFF_FFFF,  32'd1,          1, 32'd1,         1'b0, 1'b0);
    run("add_wrap",2'b00, 6'b000000, 32'hFFFF_FFFF,  32'd1,          1, 32'd0,         1'b1, 1'b0);
    run("sub_op",  2'b01, 6'b111111, 32'd10,         32'd3,          1, 32'd7,         1'b0, 1'b0);
    run("and",     2'b10, 6'b100100, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  1, 32'h00F0_00F0, 1'b0, 1'b0);
    run("or",      2'b10, 6'b100101, 32'h1234_0000,  32'h0000_5678,  1, 32'h1234_5678, 1'b0, 1'b0);
    run("nor",     2'b10, 6'b100111, 32'h0000_0000,  32'hFFFF_0000,  1, 32'h0000_FFFF, 1'b0, 1'b0);
    run("slt_f0",  2'b10, 6'b101010, 32'd5,          32'd3,          1, 32'd0,         1'b1, 1'b0);
    run("slt_fneg",2'b10, 6'b101010, 32'h8000_0000,  32'd1,          1, 32'd1,         1'b0, 1'b0);

    // Shifts, latency max(n,1)
    run("sll31",   2'b10, 6'b000100, 32'd1,          32'd31,         31, 32'h8000_0000, 1'b0, 1'b0);
    run("sll0",    2'b10, 6'b000100, 32'd1,          32'd0,          1,  32'd1,         1'b0, 1'b0);
    run("sll1",    2'b10, 6'b000100, 32'd3,          32'd1,          1,  32'd6,         1'b0, 1'b0);
    run("srl4",    2'b10, 6'b000110, 32'h8000_0000,  32'd4,          4,  32'h0800_0000, 1'b0, 1'b0);
    run("srl5hi",  2'b10, 6'b000110, 32'h0000_00F0,  32'h0000_0025,  5,  32'd7,         1'b0, 1'b0);
    run("srl_out", 2'b10, 6'b000110, 32'd1,          32'd2,          2,  32'd0,         1'b1, 1'b0);

    // Mult with an ignored start in cycle 10
    issue(2'b10, 6'b011000, 32'hFFFF_FFFF, 32'd2);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 200) begin
      if (lat == 10) begin
        bus.start = 1'b1; bus.AluOp = 2'b00; bus.A = 32'd1; bus.B = 32'd1;
      end
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
    chk("mul_lat", 64'(lat), 64'd32);
    chk("mul_hi", 64'(bus.Hi), 64'd1);
    chk("mul_res", 64'(bus.Result), 64'hFFFF_FFFE);
    chk("mul_zero", 64'(bus.Zero), 64'd0);
    chk("mul_err", 64'(bus.err), 64'd0);
    @(negedge clk);
    chk("mul_idle", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("mul_noqueue", 64'(bus.done), 64'd0);

    // Hi held across non-mult ops, illegal Funct
    run("add_hi",  2'b00, 6'b000000, 32'd2, 32'd3, 1, 32'd5, 1'b0, 1'b0);
    chk("hi_held_add", 64'(bus.Hi), 64'd1);
    run("illegal", 2'b10, 6'b111111, 32'd9, 32'd9, 1, 32'd0, 1'b1, 1'b1);
    chk("hi_held_ill", 64'(bus.Hi), 64'd1);

    run("mul2", 2'b10, 6'b011000, 32'h1234_5678, 32'h0000_0100, 32, 32'h3456_7800, 1'b0, 1'b0);
    chk("mul2_hi", 64'(bus.Hi), 64'h12);

    // MULT_EN=0 instance: mult Funct is illegal
    @(negedge clk);
    bus_nm.start = 1'b1; bus_nm.AluOp = 2'b10; bus_nm.Funct = 6'b011000;
    bus_nm.A = 32'd6; bus_nm.B = 32'd7;
    @(negedge clk);
    bus_nm.start = 1'b0;
    chk("nm_done", 64'(bus_nm.done), 64'd1);
    chk("nm_err", 64'(bus_nm.err), 64'd1);
    chk("nm_res", 64'(bus_nm.Result), 64'd0);
    chk("nm_zero", 64'(bus_nm.Zero), 64'd1);
    chk("nm_hi", 64'(bus_nm.Hi), 64'd0);

    // Reset in cycle 5 of a mult, with start held high during reset
    issue(2'b10, 6'b011000, 32'd3, 32'd5);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b1; bus.AluOp = 2'b00; bus.A = 32'd4; bus.B = 32'd4;
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_res", 64'(bus.Result), 64'd0);
    chk("abort_hi", 64'(bus.Hi), 64'd0);
    chk("abort_err", 64'(bus.err), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    chk("abort_quiet", 64'(seen), 64'd0);
    run("add_after", 2'b00, 6'b000000, 32'd7, 32'd8, 1, 32'd15, 1'b0, 1'b0);
    chk("hi_after", 64'(bus.Hi), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Parameters
REQ-001 WIDTH, default 32: datapath width in bits; legal values are 8, 16, 32 and 64.
REQ-002 MULT_EN, default 1: 1 builds the iterative multiplier; 0 makes mult an illegal op.

Interface
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request; sampled only while busy=0.
REQ-006 AluOp  in  2  00=add, 01=sub, 10=decode Funct, 11=slt.
REQ-007 Funct  in  6  R-type function field; used only when AluOp=10.
REQ-008 A, B  in  WIDTH  operands, captured on an accepted start.
REQ-009 Result  out  WIDTH  result of the last operation; held until the next done.
REQ-010 Hi  out  WIDTH  upper half of the last mult product; unchanged by all other ops.
REQ-011 Zero  out  1  1 when Result==0; registered together with Result.
REQ-012 busy  out  1  1 from the cycle after an accepted start up to and including the done cycle.
REQ-013 done  out  1  one-cycle pulse; Result, Hi, Zero and err are valid in this cycle.
REQ-014 err  out  1  1 when the completed request had an illegal Funct; qualified by done.

Function
REQ-015 Accept: start=1 and busy=0 at an edge captures A, B and the decoded op, and moves to the next state.
REQ-016 start while busy=1 is ignored and is not queued.
REQ-017 Decode when AluOp=10 (Funct -> op):
- 100000 add; 100010 sub; 100100 and; 100101 or
- 100111 nor; 101010 slt; 000100 sllv; 000110 srlv
- 011000 mult (only when MULT_EN=1)
REQ-018 Any other Funct is illegal: Result=0, Zero=1, err=1, Hi unchanged, latency 1.
REQ-019 State machine: IDLE, ALU, SHIFT, MULT.
- IDLE -> ALU on accept of add, sub, and, or, nor, slt or an illegal op.
- IDLE -> SHIFT on sllv/srlv; IDLE -> MULT on mult.
- ALU, SHIFT and MULT return to IDLE in the done cycle.
REQ-020 ALU ops: done in the first cycle after accept (latency 1).
- add/sub are modulo 2^WIDTH; carry and overflow are discarded.
- slt is a signed compare, Result = {WIDTH-1 zeros, A<B}.
REQ-021 Shifts use amount n = B[clog2(WIDTH)-1:0] and shift A by 1 bit per cycle.
- Zero fill for both directions.
- done in cycle max(n,1) after accept; n=0 gives Result=A.
REQ-022 mult is unsigned shift-add, 1 bit per cycle.
- done exactly WIDTH cycles after accept.
- {Hi, Result} = A*B as a full 2*WIDTH-bit product.
REQ-023 Result, Zero and err update only in the done cycle; Hi updates only in a mult done cycle.
REQ-024 The next start is accepted in the cycle after done, giving a throughput of 1 op per 2 cycles for ALU ops.

Reset
REQ-025 reset=1 forces state IDLE and clears Result, Hi, Zero, busy, done and err to 0.
REQ-026 reset overrides start in the same cycle.
REQ-027 reset during SHIFT or MULT aborts the operation with no done pulse and leaves all outputs 0.
REQ-028 Operation is normal from the first edge after reset deasserts.

Verification
REQ-029 WIDTH=32, AluOp=10, Funct=100010, A=5, B=7, start=1 -> next cycle: done=1, Result=0xFFFFFFFE, Zero=0, err=0.
REQ-030 AluOp=11, A=0xFFFFFFFF, B=1 -> Result=1 (signed -1<1); then AluOp=00, A=0xFFFFFFFF, B=1 -> Result=0, Zero=1.
REQ-031 Funct=000100, A=1, B=31 -> busy for 31 cycles, done in cycle 31, Result=0x80000000; repeat with B=0 -> done in cycle 1, Result=1.
REQ-032 Funct=011000, A=0xFFFFFFFF, B=2 -> done in cycle 32, Hi=1, Result=0xFFFFFFFE; a start issued in cycle 10 has no effect.
REQ-033 Funct=111111 -> done after 1 cycle, err=1, Result=0, Zero=1; with MULT_EN=0, Funct=011000 gives the same response.
REQ-034 reset in cycle 5 of a mult -> no done pulse; Result=Hi=0, busy=0; a new add is accepted on the next cycle.
